// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - tile sequencer for the NxN systolic MAC array
//
// One tile per start: weight preload, activation streaming, skew flush,
// then a handshaked drain of result rows. Every output is a register.
// a_ready is sampled on the edge that opens a COMPUTE cycle, so that
// cycle's a_valid/a_idx reflect whether the buffer had data for it.

module systolic_seq_ctrl #(
  parameter int N  = 8,
  parameter int KW = 16,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          a_ready,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          w_load_en,
  output logic [RW-1:0] w_row,
  output logic          acc_clear,
  output logic          a_valid,
  output logic [KW-1:0] a_idx,
  output logic          array_en,
  output logic          out_valid,
  output logic [RW-1:0] out_row
);

  // Flush counter must reach 2N-3 (its last value) and still represent 2N-2.
  localparam int FW = $clog2(2 * N - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] cnt_q;      // next activation index to issue; tops out at k_len
  logic [FW-1:0] flush_q;
  logic          busy_q;
  logic          done_q;
  logic          w_load_en_q;
  logic [RW-1:0] w_row_q;
  logic          acc_clear_q;
  logic          a_valid_q;
  logic [KW-1:0] a_idx_q;
  logic          array_en_q;
  logic          out_valid_q;
  logic [RW-1:0] out_row_q;

  logic          last_acc_d;
  logic          issue_slot_d;

  // Decide whether the next cycle is a COMPUTE cycle (an issue slot).
  always_comb begin
    last_acc_d   = 1'b0;
    issue_slot_d = 1'b0;
    if (state_q == S_COMPUTE) begin
      last_acc_d   = a_valid_q && (a_idx_q == (k_len_q - KW'(1)));
      issue_slot_d = !last_acc_d;
    end else if (state_q == S_LOAD_W) begin
      issue_slot_d = (w_row_q == ROW_LAST) && (k_len_q != '0);
    end
  end

  // Sequencer FSM with all array controls registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      flush_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_load_en_q <= 1'b0;
      w_row_q     <= '0;
      acc_clear_q <= 1'b0;
      a_valid_q   <= 1'b0;
      a_idx_q     <= '0;
      array_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      w_load_en_q <= 1'b0;
      acc_clear_q <= 1'b0;
      a_valid_q   <= 1'b0;
      array_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_len_q     <= k_len;
            cnt_q       <= '0;
            a_idx_q     <= '0;
            busy_q      <= 1'b1;
            w_load_en_q <= 1'b1;
            w_row_q     <= '0;
            state_q     <= S_LOAD_W;
          end
        end

        S_LOAD_W: begin
          if (w_row_q == ROW_LAST) begin
            w_row_q <= '0;
            if (k_len_q != '0) begin
              state_q <= S_COMPUTE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            w_load_en_q <= 1'b1;
            w_row_q     <= w_row_q + RW'(1);
          end
        end

        S_COMPUTE: begin
          if (last_acc_d) begin
            flush_q    <= '0;
            array_en_q <= 1'b1;
            state_q    <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            out_valid_q <= 1'b1;
            out_row_q   <= '0;
            state_q     <= S_DRAIN;
          end else begin
            array_en_q <= 1'b1;
            flush_q    <= flush_q + FW'(1);
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (out_row_q == ROW_LAST) begin
              out_row_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              out_valid_q <= 1'b1;
              out_row_q   <= out_row_q + RW'(1);
            end
          end else begin
            out_valid_q <= 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // Issue slot: the buffer either hands over vector cnt_q or the slot idles
      // with a_idx parked on the vector still owed.
      if (issue_slot_d) begin
        a_idx_q <= cnt_q;
        if (a_ready) begin
          a_valid_q   <= 1'b1;
          array_en_q  <= 1'b1;
          acc_clear_q <= (cnt_q == '0);
          cnt_q       <= cnt_q + KW'(1);
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_load_en = w_load_en_q;
  assign w_row     = w_row_q;
  assign acc_clear = acc_clear_q;
  assign a_valid   = a_valid_q;
  assign a_idx     = a_idx_q;
  assign array_en  = array_en_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for the N×N systolic MAC array inside TOP. It runs one tile per `start`: weight preload, activation streaming with backpressure, skew flush, then a handshaked drain of result rows. It sits between the host/config side and the array and its buffers, and drives every array enable and index.

## Interface
- `N`, default 8: array dimension (rows = columns); must be ≥ 2.
- `KW`, default 16: width of the activation count `k_len`.
- `RW`, default clog2(N): width of the row indices.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `start`, in, 1: tile request; sampled only in IDLE, ignored otherwise.
- `k_len`, in, KW: number of activation vectors for the tile; latched when `start` is accepted.
- `a_ready`, in, 1: activation buffer has data this cycle.
- `out_ready`, in, 1: result sink accepts the row this cycle.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `w_load_en`, out, 1: write weight row `w_row` into the array.
- `w_row`, out, RW: weight row index.
- `acc_clear`, out, 1: accumulators load instead of add; coincides with the first `a_valid` of the tile.
- `a_valid`, out, 1: activation vector `a_idx` enters the array.
- `a_idx`, out, KW: activation read index.
- `array_en`, out, 1: array shift/MAC enable.
- `out_valid`, out, 1: result row `out_row` is presented.
- `out_row`, out, RW: result row index.

## Operation
- All outputs are registered. Reset value of every output is 0; state is IDLE; counters are 0.
- IDLE: on `start`=1, latch `k_len` and go to LOAD_W.
- LOAD_W: `w_load_en`=1 and `w_row` runs 0..N-1, one row per cycle. After row N-1:
  - go to COMPUTE if latched k_len ≠ 0;
  - go to DONE if k_len = 0, with no `a_valid`, `acc_clear` or `out_valid` asserted for the tile.
- COMPUTE, per cycle:
  - If `a_ready`=1: `a_valid`=1, `array_en`=1, `a_idx` = current count, and the count increments.
  - If `a_ready`=0: `a_valid`=0, `array_en`=0, and `a_idx`/count hold.
  - `acc_clear`=1 only on the cycle carrying `a_idx`=0 with `a_valid`=1.
  - After the vector with `a_idx` = k_len−1 is accepted, go to FLUSH.
- FLUSH: exactly 2N−2 cycles with `array_en`=1 and `a_valid`=0. These cycles drain the skew and do not depend on `a_ready`.
- DRAIN: `out_valid`=1 and `out_row` starts at 0.
  - `out_row` advances only on a cycle where `out_valid` & `out_ready` are both high.
  - `out_row` holds while `out_ready`=0, and `out_valid` stays high.
  - After the handshake on row N−1, go to DONE. `array_en`=0 throughout DRAIN.
- DONE: `done`=1 for one cycle, then return to IDLE. `start` in the DONE cycle is ignored.
- `rst` asserted in any state: the next cycle is IDLE with all outputs 0 and any partial tile abandoned.
- Arithmetic:
  - `a_idx` count is KW bits and never wraps, because it stops at k_len−1. k_len = 2^KW−1 is legal.
  - The FLUSH counter must hold 2N−2.

## Timing
- With `start` accepted at cycle t and `a_ready`=`out_ready`=1 throughout:
  - LOAD_W: t+1 .. t+N
  - COMPUTE: t+N+1 .. t+N+k_len
  - FLUSH: t+N+k_len+1 .. t+3N+k_len−2
  - DRAIN: t+3N+k_len−1 .. t+4N+k_len−2
  - `done`: t+4N+k_len−1
- Each cycle of `a_ready`=0 in COMPUTE, and each cycle of `out_ready`=0 in DRAIN, adds exactly one cycle to the total.
- k_len = 0: `done` at t+N+1.
- `busy` rises at t+1 and falls the cycle after `done`. A new `start` is accepted at the earliest in the cycle after `done`.

## Test plan
- Reset, then N=8, k_len=4, ready inputs held high, `start` at cycle 0:
  - `w_row` 0..7 on cycles 1–8;
  - `a_idx` 0..3 on cycles 9–12, with `acc_clear` only on cycle 9;
  - `array_en` high on cycles 9–26;
  - `out_row` 0..7 on cycles 27–34;
  - `done` on cycle 35.
- Same tile with `a_ready` low on cycles 10–11: `a_idx`=1 is held with `a_valid`=0 for those cycles, and `done` moves to cycle 37.
- Same tile with `out_ready` low for 3 cycles while `out_row`=5: `out_row`=5 holds with `out_valid`=1, and `done` moves to cycle 38.
- k_len=0: only LOAD_W runs, with `done` at cycle 9; `a_valid`, `acc_clear` and `out_valid` never assert.
- `rst` pulsed during FLUSH: next cycle all outputs are 0 and `busy`=0; a fresh `start` then reproduces the scenario 1 timing.
- `start` pulsed while busy and on the `done` cycle: ignored, with no second tile. `start` on the cycle after `done` is accepted.
